ysyx_23060061_lsu_stage: RTL

//  Multi-cycle load/store stage between EXU and WBU; replaces the combinational DPI LSU.

---
 rtl/ysyx_23060061_lsu_stage_if.sv | 50 +++++
 rtl/ysyx_23060061_lsu_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_lsu_stage_if.sv
// Bus bundle for the LSU stage: EXU request side, memory port and WBU result side.
// slave  : view taken by the LSU stage itself.
// master : view taken by the surrounding pipeline / memory model.
interface ysyx_23060061_lsu_stage_if #(
    parameter int unsigned PAYLOAD_W = 64
);
    // EXU -> LSU
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_op;
    logic [2:0]           in_ext;
    logic [31:0]          in_addr;
    logic [31:0]          in_wdata;
    logic [PAYLOAD_W-1:0] in_payload;

    // LSU <-> memory
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [3:0]           mem_wmask;
    logic                 mem_rsp_valid;
    logic [31:0]          mem_rdata;

    // LSU -> WBU
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_rdata;
    logic                 out_err;
    logic [PAYLOAD_W-1:0] out_payload;

    modport slave (
        input  in_valid, in_op, in_ext, in_addr, in_wdata, in_payload,
        output in_ready,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output out_valid, out_rdata, out_err, out_payload,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_ext, in_addr, in_wdata, in_payload,
        input  in_ready,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  out_valid, out_rdata, out_err, out_payload,
        output out_ready
    );
endinterface

// File: rtl/ysyx_23060061_lsu_stage.sv
// Multi-cycle load/store stage between EXU and WBU.
// Takes one op at a time, issues at most one word-aligned memory request, aligns
// byte lanes, extends load data and hands a registered result plus the opaque
// payload to WBU. All bus outputs are registered.
// Optional feature: define LSU_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles.
module ysyx_23060061_lsu_stage #(
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    ysyx_23060061_lsu_stage_if.slave        bus
);

    localparam int unsigned CNT_W = 8;

    if (TIMEOUT == 0 || TIMEOUT > 255) begin : g_timeout_range
        $error("TIMEOUT must lie in 1..255 to fit the 8-bit wait counter");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Registered outputs
    logic                 r_in_ready;
    logic                 r_mem_req_valid;
    logic                 r_mem_we;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic [3:0]           r_mem_wmask;
    logic                 r_out_valid;
    logic [31:0]          r_out_rdata;
    logic                 r_out_err;
    logic [PAYLOAD_W-1:0] r_out_payload;

    // Op context kept for load extraction
    logic                 r_is_load;
    logic [2:0]           r_ext;
    logic [1:0]           r_lane;

    // Next values of registered outputs
    logic                 w_mem_req_valid_nxt;
    logic                 w_out_valid_nxt;
    logic [31:0]          w_out_rdata_nxt;
    logic                 w_out_err_nxt;

    logic                 w_accept;
    logic                 w_is_load;
    logic                 w_is_store;
    logic                 w_is_mem;
    logic                 w_size_b;
    logic                 w_size_h;
    logic                 w_misalign;
    logic [3:0]           w_wmask_in;
    logic [31:0]          w_wdata_in;
    logic [31:0]          w_shifted;
    logic [31:0]          w_load_val;
    logic                 w_timeout;

    assign bus.in_ready      = r_in_ready;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.mem_wmask     = r_mem_wmask;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_rdata     = r_out_rdata;
    assign bus.out_err       = r_out_err;
    assign bus.out_payload   = r_out_payload;

    // Decode of the incoming op: access size, alignment, store lanes
    always_comb begin
        w_accept   = bus.in_valid & r_in_ready;
        w_is_load  = (bus.in_op == 2'b01);
        w_is_store = (bus.in_op == 2'b10);
        w_is_mem   = w_is_load | w_is_store;
        w_size_h   = (bus.in_ext == 3'b001) | (bus.in_ext == 3'b010);
        w_size_b   = (bus.in_ext == 3'b011) | (bus.in_ext == 3'b100);

        if (w_size_b) begin
            w_misalign = 1'b0;
        end else if (w_size_h) begin
            w_misalign = bus.in_addr[0];
        end else begin
            w_misalign = (bus.in_addr[1:0] != 2'b00);
        end

        if (w_size_b) begin
            w_wmask_in = 4'(4'b0001 << bus.in_addr[1:0]);
            w_wdata_in = {4{bus.in_wdata[7:0]}};
        end else if (w_size_h) begin
            w_wmask_in = 4'(4'b0011 << bus.in_addr[1:0]);
            w_wdata_in = {2{bus.in_wdata[15:0]}};
        end else begin
            w_wmask_in = 4'b1111;
            w_wdata_in = bus.in_wdata;
        end
    end

    // Shift the returned word down to the addressed lane and extend it
    always_comb begin
        w_shifted = bus.mem_rdata >> {r_lane, 3'b000};
        case (r_ext)
            3'b001:  w_load_val = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_val = {16'h0000, w_shifted[15:0]};
            3'b011:  w_load_val = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_val = {24'h000000, w_shifted[7:0]};
            default: w_load_val = w_shifted;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] r_wait_cnt;

    // Wait-cycle counter: cleared on entering WAIT, counts every WAIT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_REQ && bus.mem_req_ready) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= CNT_W'(r_wait_cnt + 1'b1);
        end
    end

    assign w_timeout = (CNT_W'(r_wait_cnt + 1'b1) == CNT_W'(TIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of the handshake/result outputs
    always_comb begin
        w_state_nxt         = r_state;
        w_mem_req_valid_nxt = r_mem_req_valid;
        w_out_valid_nxt     = r_out_valid;
        w_out_rdata_nxt     = r_out_rdata;
        w_out_err_nxt       = r_out_err;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_out_rdata_nxt = 32'h0;
                    w_out_err_nxt   = w_is_mem & w_misalign;
                    if (w_is_mem && !w_misalign) begin
                        w_state_nxt         = S_REQ;
                        w_mem_req_valid_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_RESP;
                        w_out_valid_nxt = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    w_state_nxt         = S_WAIT;
                    w_mem_req_valid_nxt = 1'b0;
                end
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    w_state_nxt     = S_RESP;
                    w_out_valid_nxt = 1'b1;
                    w_out_rdata_nxt = r_is_load ? w_load_val : 32'h0;
                    w_out_err_nxt   = 1'b0;
                end else if (w_timeout) begin
                    w_state_nxt     = S_RESP;
                    w_out_valid_nxt = 1'b1;
                    w_out_rdata_nxt = 32'h0;
                    w_out_err_nxt   = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.out_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output registers: handshake/result from the FSM, request fields and
    // payload captured when an op is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready      <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_we        <= 1'b0;
            r_mem_addr      <= 32'h0;
            r_mem_wdata     <= 32'h0;
            r_mem_wmask     <= 4'h0;
            r_out_valid     <= 1'b0;
            r_out_rdata     <= 32'h0;
            r_out_err       <= 1'b0;
            r_out_payload   <= '0;
            r_is_load       <= 1'b0;
            r_ext           <= 3'b000;
            r_lane          <= 2'b00;
        end else begin
            r_in_ready      <= (w_state_nxt == S_IDLE);
            r_mem_req_valid <= w_mem_req_valid_nxt;
            r_out_valid     <= w_out_valid_nxt;
            r_out_rdata     <= w_out_rdata_nxt;
            r_out_err       <= w_out_err_nxt;
            if (w_accept) begin
                r_out_payload <= bus.in_payload;
                r_is_load     <= w_is_load;
                r_ext         <= bus.in_ext;
                r_lane        <= bus.in_addr[1:0];
                if (w_is_mem && !w_misalign) begin
                    r_mem_we    <= w_is_store;
                    r_mem_addr  <= {bus.in_addr[31:2], 2'b00};
                    r_mem_wdata <= w_is_store ? w_wdata_in : 32'h0;
                    r_mem_wmask <= w_is_store ? w_wmask_in : 4'h0;
                end
            end
        end
    end

endmodule
